// File: rtl/fifo_uart_tx_if.sv
// Show-ahead FIFO read port: the FIFO supplies empty/fifo_data, the consumer returns pop.
interface fifo_uart_tx_if #(
  parameter int unsigned WIDTH = 32'd8
);
  logic             empty;
  logic [WIDTH-1:0] fifo_data;
  logic             pop;

  modport master (output pop, input empty, input fifo_data);
  modport slave  (input pop, output empty, output fifo_data);
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead FIFO one word at a time and serializes each word as a UART frame:
// start bit, WIDTH data bits LSB-first, optional parity, then STOP_BITS stop bits.
module fifo_uart_tx #(
  parameter int unsigned WIDTH        = 32'd8,
  parameter int unsigned CLKS_PER_BIT = 32'd16,
  parameter int unsigned PARITY       = 32'd0,
  parameter int unsigned STOP_BITS    = 32'd1
) (
  input  logic                  rdclk,
  input  logic                  rdrst,
  input  logic                  enable,
  fifo_uart_tx_if.master        fifo,
  output logic                  txd,
  output logic                  busy
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 32'd1;
  localparam int unsigned BIT_W  = $clog2(WIDTH) + 32'd1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 32'd1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 32'd1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  shift_r;
  logic [BAUD_W-1:0] baud_r;
  logic [BIT_W-1:0]  bit_r;
  logic              stop_r;
  logic              parity_r;
  logic [1:0]        guard_r;
  logic              txd_r;
  logic              busy_r;
  logic              guard_done_s;
  logic              baud_last_s;
  logic              pop_s;

  function automatic logic parity_of(input logic [WIDTH-1:0] d);
    logic p;
    case (PARITY)
      32'd1:   p = ^d;
      32'd2:   p = ~^d;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  assign guard_done_s = (guard_r == 2'd3);
  assign baud_last_s  = (baud_r == BAUD_LAST);
  // pop is combinational so the word is taken in the same IDLE cycle the FIFO shows it
  assign pop_s        = (state_r == S_IDLE) & enable & ~fifo.empty & guard_done_s;
  assign fifo.pop     = pop_s;
  assign txd          = txd_r;
  assign busy         = busy_r;

  // Frame sequencer: startup guard, baud/bit counting, shift register and registered line outputs
  always_ff @(posedge rdclk or negedge rdrst) begin
    if (!rdrst) begin
      state_r  <= S_IDLE;
      shift_r  <= '0;
      baud_r   <= '0;
      bit_r    <= '0;
      stop_r   <= 1'b0;
      parity_r <= 1'b0;
      guard_r  <= 2'd0;
      txd_r    <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      if (!guard_done_s) begin
        guard_r <= guard_r + 2'd1;
      end
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            shift_r  <= fifo.fifo_data;
            parity_r <= parity_of(fifo.fifo_data);
            baud_r   <= '0;
            bit_r    <= '0;
            stop_r   <= 1'b0;
            state_r  <= S_START;
            txd_r    <= 1'b0;
            busy_r   <= 1'b1;
          end
        end
        S_START: begin
          if (baud_last_s) begin
            baud_r  <= '0;
            state_r <= S_DATA;
            txd_r   <= shift_r[0];
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (baud_last_s) begin
            baud_r <= '0;
            if (bit_r == BIT_LAST) begin
              if (PARITY != 32'd0) begin
                state_r <= S_PARITY;
                txd_r   <= parity_r;
              end else begin
                state_r <= S_STOP;
                txd_r   <= 1'b1;
              end
            end else begin
              // next bit is already at shift_r[1], so the line updates on the same edge as the shift
              bit_r   <= bit_r + BIT_W'(1);
              shift_r <= shift_r >> 1;
              txd_r   <= shift_r[1];
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        S_PARITY: begin
          if (baud_last_s) begin
            baud_r  <= '0;
            state_r <= S_STOP;
            txd_r   <= 1'b1;
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (baud_last_s) begin
            baud_r <= '0;
            if (stop_r == STOP_LAST) begin
              stop_r  <= 1'b0;
              state_r <= S_IDLE;
              txd_r   <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              stop_r <= 1'b1;
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        default: begin
          state_r <= S_IDLE;
          txd_r   <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: frame table on three parity/stop configurations plus
// guard, back-to-back, enable gating and mid-frame reset sequences.
module tb_fifo_uart_tx;

  typedef struct {
    int unsigned dut;
    logic [7:0]  data;
    logic [11:0] exp;   // expected line value per bit period, bit 0 = start bit
    int          len;
  } vec_t;

  logic       rdclk;
  logic       rdrst;
  logic       enable;
  logic [2:0] empty_a;
  logic [7:0] data_a [3];
  logic [2:0] pop_a;
  logic [2:0] txd_a;
  logic [2:0] busy_a;
  int         errors;
  int         checks;
  int         cyc_cnt;
  vec_t       vecs [6];

  fifo_uart_tx_if #(.WIDTH(8)) if0 ();
  fifo_uart_tx_if #(.WIDTH(8)) if1 ();
  fifo_uart_tx_if #(.WIDTH(8)) if2 ();

  assign if0.empty = empty_a[0];  assign if0.fifo_data = data_a[0];  assign pop_a[0] = if0.pop;
  assign if1.empty = empty_a[1];  assign if1.fifo_data = data_a[1];  assign pop_a[1] = if1.pop;
  assign if2.empty = empty_a[2];  assign if2.fifo_data = data_a[2];  assign pop_a[2] = if2.pop;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut0 (
    .rdclk(rdclk), .rdrst(rdrst), .enable(enable), .fifo(if0), .txd(txd_a[0]), .busy(busy_a[0]));
  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) dut1 (
    .rdclk(rdclk), .rdrst(rdrst), .enable(enable), .fifo(if1), .txd(txd_a[1]), .busy(busy_a[1]));
  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) dut2 (
    .rdclk(rdclk), .rdrst(rdrst), .enable(enable), .fifo(if2), .txd(txd_a[2]), .busy(busy_a[2]));

  initial rdclk = 1'b0;
  always #5 rdclk = ~rdclk;

  initial cyc_cnt = 0;
  always @(posedge rdclk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic wait_pop(input int unsigned d, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge rdclk);
      if (pop_a[d] === 1'b1) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Present one word, wait for its pop, then sample every bit mid-period and time busy.
  task automatic run_vec(input vec_t v, input string name);
    logic [11:0] got;
    int          busy_len;
    int          pops;
    logic        last_txd;
    @(posedge rdclk); #1;
    data_a[v.dut]  = v.data;
    empty_a[v.dut] = 1'b0;
    wait_pop(v.dut, {name, "_pop"});
    @(posedge rdclk); #1;
    empty_a[v.dut] = 1'b1;
    got = '0; busy_len = 0; pops = 0; last_txd = 1'b0;
    for (int k = 1; k <= v.len + 1; k++) begin
      @(negedge rdclk);
      if (busy_a[v.dut]) busy_len++;
      if (pop_a[v.dut]) pops++;
      if (k <= v.len && ((k - 1) % 4) == 2) got[(k - 1) / 4] = txd_a[v.dut];
      if (k == v.len + 1) last_txd = txd_a[v.dut];
    end
    check({name, "_bits"}, 32'(got), 32'(v.exp));
    check({name, "_busy_len"}, 32'(busy_len), 32'(v.len));
    check({name, "_extra_pop"}, 32'(pops), 32'd0);
    check({name, "_idle_txd"}, 32'(last_txd), 32'd1);
  endtask

  initial begin
    int   pops;
    int   lows;
    int   highs;
    int   t1;
    int   t2;
    bit   seen;
    logic txd40;
    logic txd_at;
    logic busy_at;
    logic b40;
    logic b41;
    logic [11:0] got;

    vecs[0] = '{dut: 0, data: 8'hA5, exp: 12'b0011_0100_1010, len: 40};
    vecs[1] = '{dut: 0, data: 8'h01, exp: 12'b0010_0000_0010, len: 40};
    vecs[2] = '{dut: 0, data: 8'hFF, exp: 12'b0011_1111_1110, len: 40};
    vecs[3] = '{dut: 0, data: 8'h3C, exp: 12'b0010_0111_1000, len: 40};
    vecs[4] = '{dut: 1, data: 8'h07, exp: 12'b1110_0000_1110, len: 48};
    vecs[5] = '{dut: 2, data: 8'h07, exp: 12'b1100_0000_1110, len: 48};

    errors = 0; checks = 0;
    rdrst = 1'b0; enable = 1'b1;
    empty_a = 3'b110;
    data_a[0] = 8'h5A; data_a[1] = 8'h00; data_a[2] = 8'h00;

    // Reset state, with a word already offered on dut0
    repeat (2) @(posedge rdclk);
    @(negedge rdclk);
    check("rst_txd", 32'(txd_a), 32'd7);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_pop", 32'(pop_a), 32'd0);

    // Startup guard: three cycles with no pop, then pop offered on the fourth
    @(posedge rdclk); #1;
    rdrst = 1'b1;
    pops = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge rdclk);
      if (pop_a[0]) pops++;
    end
    check("guard_hold", 32'(pops), 32'd0);
    @(negedge rdclk);
    check("guard_done_pop", 32'(pop_a[0]), 32'd1);
    empty_a[0] = 1'b1;
    #1;
    check("guard_pop_drop", 32'(pop_a[0]), 32'd0);
    pops = 0; lows = 0; highs = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge rdclk);
      if (pop_a != 3'b000) pops++;
      if (txd_a != 3'b111) lows++;
      if (busy_a != 3'b000) highs++;
    end
    check("idle_pop", 32'(pops), 32'd0);
    check("idle_txd", 32'(lows), 32'd0);
    check("idle_busy", 32'(highs), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: 0x01 then 0xFF with empty held low
    @(posedge rdclk); #1;
    data_a[0] = 8'h01; empty_a[0] = 1'b0;
    wait_pop(0, "b2b_pop1");
    t1 = cyc_cnt;
    @(posedge rdclk); #1;
    data_a[0] = 8'hFF;
    seen = 1'b0; t2 = 0; txd40 = 1'b0; txd_at = 1'b0; busy_at = 1'b1;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge rdclk);
      if (k == 40) txd40 = txd_a[0];
      if (pop_a[0]) begin
        seen = 1'b1; t2 = cyc_cnt; txd_at = txd_a[0]; busy_at = busy_a[0];
      end
    end
    @(posedge rdclk); #1;
    empty_a[0] = 1'b1;
    check("b2b_pop2", 32'(seen), 32'd1);
    check("b2b_gap", 32'(t2 - t1), 32'd41);
    check("b2b_stop_txd", 32'(txd40), 32'd1);
    check("b2b_idle_txd", 32'(txd_at), 32'd1);
    check("b2b_idle_busy", 32'(busy_at), 32'd0);
    repeat (45) @(negedge rdclk);

    // Enable dropped during DATA: frame completes, no pop until enable returns
    @(posedge rdclk); #1;
    data_a[0] = 8'h3C; empty_a[0] = 1'b0; enable = 1'b1;
    wait_pop(0, "en_pop");
    @(posedge rdclk); #1;
    got = '0; pops = 0; b40 = 1'b0; b41 = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge rdclk);
      if (pop_a[0]) pops++;
      if (k <= 40 && ((k - 1) % 4) == 2) got[(k - 1) / 4] = txd_a[0];
      if (k == 10) enable = 1'b0;
      if (k == 40) b40 = busy_a[0];
      if (k == 41) b41 = busy_a[0];
    end
    check("en_bits", 32'(got), 32'h278);
    check("en_no_pop", 32'(pops), 32'd0);
    check("en_busy_last", 32'(b40), 32'd1);
    check("en_busy_end", 32'(b41), 32'd0);
    @(posedge rdclk); #1;
    enable = 1'b1;
    @(negedge rdclk);
    check("en_resume_pop", 32'(pop_a[0]), 32'd1);
    empty_a[0] = 1'b1;
    repeat (3) @(negedge rdclk);

    // Reset during data bit 3, then the next word goes out from its start bit
    @(posedge rdclk); #1;
    data_a[0] = 8'hA5; empty_a[0] = 1'b0;
    wait_pop(0, "rst_mid_pop");
    @(posedge rdclk); #1;
    repeat (13) @(posedge rdclk);
    #3;
    check("rst_mid_busy_before", 32'(busy_a[0]), 32'd1);
    rdrst = 1'b0;
    #1;
    check("rst_mid_txd", 32'(txd_a[0]), 32'd1);
    check("rst_mid_busy", 32'(busy_a[0]), 32'd0);
    check("rst_mid_pop", 32'(pop_a[0]), 32'd0);
    @(posedge rdclk); #1;
    rdrst = 1'b1;
    run_vec(vecs[3], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
